// File: rtl/queue_ctrl_if.sv
// Producer/consumer bundle for queue_ctrl: two push ports, one pop port and the status outputs.
// The master modport is the producer/consumer side and the slave modport is the controller.
interface queue_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] din0;
  logic             req1;
  logic [WIDTH-1:0] din1;
  logic             gnt0;
  logic             gnt1;
  logic             pop;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic [3:0]       pcount;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output req0, din0, req1, din1, pop,
    input  gnt0, gnt1, dout, dvalid, pcount, empty, full, err
  );

  modport slave (
    input  req0, din0, req1, din1, pop,
    output gnt0, gnt1, dout, dvalid, pcount, empty, full, err
  );
endinterface

// File: rtl/queue_ctrl.sv
// Queue controller: register-array storage, round-robin shared write port, one pop port.
// Defining QCTRL_ERR_EN compiles a sticky underflow flag on err; otherwise err is tied to 0.
module queue_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7
) (
  input logic         clk,
  input logic         rst_n,
  queue_ctrl_if.slave q
);
  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(DEPTH - 1);
  localparam logic [3:0]     CNT_FULL = 4'(DEPTH);

  logic [WIDTH-1:0] mem [2**PW];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [3:0]       pcount;
  logic             lg;
  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;

  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             slot;
  logic             gnt0;
  logic             gnt1;
  logic             push;
  logic [WIDTH-1:0] wdata;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (pcount == 4'd0);
  assign full   = (pcount == CNT_FULL);
  assign pop_ok = q.pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue can still accept a push.
  assign slot   = ~full | pop_ok;

  // lg records the last granted producer; on a tie the other one wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && slot) begin
      if (q.req0 && q.req1) begin
        gnt0 = lg;
        gnt1 = ~lg;
      end else begin
        gnt0 = q.req0;
        gnt1 = q.req1;
      end
    end
  end

  assign push  = gnt0 | gnt1;
  assign wdata = gnt1 ? q.din1 : q.din0;

  // Storage is never reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pcount  <= 4'd0;
      lg      <= 1'b1;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
        lg     <= gnt1;
      end
      // Pop stage: registered read of the oldest entry
      if (pop_ok) begin
        dout_p1 <= mem[rd_ptr];
        rd_ptr  <= ptr_next(rd_ptr);
      end
      vld_p1 <= pop_ok;
      case ({push, pop_ok})
        2'b10:   pcount <= pcount + 4'd1;
        2'b01:   pcount <= pcount - 4'd1;
        default: pcount <= pcount;
      endcase
    end
  end

`ifdef QCTRL_ERR_EN
  logic err_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_r <= 1'b0;
    else if (q.pop && empty)    err_r <= 1'b1;
  end
  assign q.err = err_r;
`else
  assign q.err = 1'b0;
`endif

  assign q.gnt0   = gnt0;
  assign q.gnt1   = gnt1;
  assign q.dout   = dout_p1;
  assign q.dvalid = vld_p1;
  assign q.pcount = pcount;
  assign q.empty  = empty;
  assign q.full   = full;
endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench for queue_ctrl: directed scenarios then randomized traffic against a queue model.
module tb_queue_ctrl;
  localparam int W = 8;
  localparam int D = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  queue_ctrl_if #(.WIDTH(W)) q ();
  queue_ctrl #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .q(q));

  typedef struct {
    logic         g0;
    logic         g1;
    logic [3:0]   cnt;
    logic         dv;
    logic [W-1:0] dout;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mq[$];
  logic         lg_m;
  logic [W-1:0] dout_m;
  logic         err_m;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    lg_m   = 1'b1;
    dout_m = '0;
    err_m  = 1'b0;
  endtask

  // Called at posedge+1: drives one cycle of stimulus, records the expectation, advances to next posedge+1.
  task automatic step(input logic r0, input logic [W-1:0] d0, input logic r1,
                      input logic [W-1:0] d1, input logic p, output logic g0, output logic g1);
    exp_t e;
    bit   has_room;
    bit   do_pop;
    q.req0 = r0; q.din0 = d0; q.req1 = r1; q.din1 = d1; q.pop = p;
    do_pop   = p && (mq.size() > 0);
    has_room = (mq.size() < D) || do_pop;
    g0 = 1'b0; g1 = 1'b0;
    if (has_room) begin
      if (r0 && r1) begin
        if (lg_m) g0 = 1'b1; else g1 = 1'b1;
      end else begin
        g0 = r0; g1 = r1;
      end
    end
`ifdef QCTRL_ERR_EN
    if (p && mq.size() == 0) err_m = 1'b1;
`endif
    e.dv = do_pop;
    if (do_pop) dout_m = mq.pop_front();
    if (g0) begin mq.push_back(d0); lg_m = 1'b0; end
    if (g1) begin mq.push_back(d1); lg_m = 1'b1; end
    e.g0 = g0; e.g1 = g1; e.dout = dout_m; e.err = err_m;
    e.cnt = 4'(mq.size());
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: grants before the edge, registered outputs after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("gnt0", 32'(q.gnt0), 32'(e.g0));
        chk("gnt1", 32'(q.gnt1), 32'(e.g1));
        @(posedge clk);
        #2;
        chk("pcount", 32'(q.pcount), 32'(e.cnt));
        chk("empty",  32'(q.empty),  32'(e.cnt == 0));
        chk("full",   32'(q.full),   32'(e.cnt == 4'(D)));
        chk("dvalid", 32'(q.dvalid), 32'(e.dv));
        chk("dout",   32'(q.dout),   32'(e.dout));
        chk("err",    32'(q.err),    32'(e.err));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin #1; t++; end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pcount"}, 32'(q.pcount), 32'd0);
    chk({tag, "_empty"},  32'(q.empty),  32'd1);
    chk({tag, "_full"},   32'(q.full),   32'd0);
    chk({tag, "_dvalid"}, 32'(q.dvalid), 32'd0);
    chk({tag, "_dout"},   32'(q.dout),   32'd0);
    chk({tag, "_gnt0"},   32'(q.gnt0),   32'd0);
    chk({tag, "_gnt1"},   32'(q.gnt1),   32'd0);
    chk({tag, "_err"},    32'(q.err),    32'd0);
  endtask

  // Asserts reset away from the clock edge while both producers request.
  task automatic mid_reset(input string tag);
    drain();
    #1;
    q.req0 = 1'b1; q.req1 = 1'b1; q.pop = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    model_reset();
    @(negedge clk);
    q.req0 = 1'b0; q.req1 = 1'b0; q.pop = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1;
    logic h0, h1, r0, r1, p;
    logic [W-1:0] hd0, hd1, d0, d1;
    q.req0 = 1'b1; q.req1 = 1'b1; q.pop = 1'b0; q.din0 = '0; q.din1 = '0;
    model_reset();
    #2;
    check_reset_state("rst");
    @(negedge clk);
    q.req0 = 1'b0; q.req1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, then stall on full
    for (int i = 0; i < D; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 8'h00, 1'b0, g0, g1);
    step(1'b1, 8'h18, 1'b0, 8'h00, 1'b0, g0, g1);
    chk("stall_pcount", 32'(q.pcount), 32'(D));
    // Push and pop together on full, then drain through the wrap
    step(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, g0, g1);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, g0, g1);
    chk("wrap_last_dout", 32'(q.dout), 32'h5A);
    // Underflow, then idle so the flag is seen to hold
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, g0, g1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, g0, g1);
    // Round-robin with both producers held
    mid_reset("rst_a");
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0, g0, g1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, g0, g1);
    // Reset mid-stream at pcount 4, then a push/pop round trip
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 8'h00, 1'b0, g0, g1);
    chk("pre_rst_pcount", 32'(q.pcount), 32'd4);
    mid_reset("rst_b");
    step(1'b1, 8'h55, 1'b0, 8'h00, 1'b0, g0, g1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, g0, g1);
    chk("rt_dout", 32'(q.dout), 32'h55);
    step(1'b1, 8'h66, 1'b1, 8'h77, 1'b1, g0, g1);

    // Random traffic; a stalled producer holds its request and data
    h0 = 1'b0; h1 = 1'b0; hd0 = '0; hd1 = '0;
    for (int i = 0; i < 400; i++) begin
      r0 = h0 ? 1'b1 : ($urandom_range(0, 99) < 55);
      d0 = h0 ? hd0 : W'($urandom);
      r1 = h1 ? 1'b1 : ($urandom_range(0, 99) < 55);
      d1 = h1 ? hd1 : W'($urandom);
      p  = ($urandom_range(0, 99) < 45);
      step(r0, d0, r1, d1, p, g0, g1);
      h0 = r0 && !g0; hd0 = d0;
      h1 = r1 && !g1; hd1 = d1;
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, g0, g1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/queue_ctrl.md
# queue_ctrl

Controller for the instruction/data queue: owns the storage, read/write pointers and occupancy count, and shares the single write port between two producers with round-robin arbitration. It drains to one consumer and exports `pcount`, `empty` and `full` with the same encoding the rest of the design uses: full at `pcount == DEPTH`, empty at 0. It sits between the producer units and the consumer stage.

## Interface
- `WIDTH`, 8, data width in bits.
- `DEPTH`, 7, number of entries; legal range 2..15 so `pcount` fits in 4 bits.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`  in  1  producer 0 push request.
- `din0`  in  WIDTH  producer 0 data.
- `req1`  in  1  producer 1 push request.
- `din1`  in  WIDTH  producer 1 data.
- `gnt0`  out  1  producer 0 push accepted this cycle.
- `gnt1`  out  1  producer 1 push accepted this cycle.
- `pop`  in  1  consumer read request.
- `dout`  out  WIDTH  popped data, registered.
- `dvalid`  out  1  `dout` holds data popped on the previous edge.
- `pcount`  out  4  occupancy, registered.
- `empty`  out  1  `pcount == 0`.
- `full`  out  1  `pcount == DEPTH`.
- `err`  out  1  sticky underflow flag (see Configuration).

## Operation
- **Storage:** DEPTH x WIDTH register array. `wr_ptr` and `rd_ptr` count 0..DEPTH-1 and wrap from DEPTH-1 to 0.
- **Pop accept:** `pop_ok = pop & ~empty`.
- **Push slot:** a push slot exists when `~full | pop_ok`, so a push into a full queue succeeds if a pop is accepted in the same cycle.
- **Arbitration:**
  - Grants are combinational from the current cycle's requests; at most one grant per cycle.
  - Only req0: `gnt0 = 1`. Only req1: `gnt1 = 1`.
  - Both: grant the producer not recorded in last-granted register `lg`.
  - `lg` updates only on a grant.
  - No push slot: both grants are 0 and `lg` is unchanged.
- **Push:** on the edge of a granted cycle, the selected `din` is written at `wr_ptr` and `wr_ptr` advances.
- **Pop:** on the edge of a `pop_ok` cycle:
  - `dout <= mem[rd_ptr]`, `rd_ptr` advances, `dvalid <= 1`.
  - Otherwise `dvalid <= 0` and `dout` holds its value.
- **Count update:**
  - Push only: `pcount + 1`.
  - Pop only: `pcount - 1`.
  - Both or neither: unchanged.
- **Boundary conditions:**
  - Pop on empty is ignored; `pcount` stays 0.
  - Simultaneous push and pop on empty: the pop is ignored, the push lands, `pcount` goes 0 to 1.
  - Push and pop on full: both occur, `pcount` stays DEPTH.
  - Request while full with no pop: the request stalls (no grant) and the producer holds `req`/`din`.
- **Flags:** `empty` and `full` are decoded combinationally from the `pcount` register.
- **Reset, asserted at any time, with immediate effect:**
  - `pcount = 0`, `wr_ptr = rd_ptr = 0`, `empty = 1`, `full = 0`.
  - `dout = 0`, `dvalid = 0`, `err = 0`.
  - `lg = 1`, so req0 wins the first tie.
  - Grants are 0 while `rst_n` is low.
  - Array contents are not cleared and are don't-care.

## Timing
- Grant latency: 0 cycles; `gnt` is valid in the same cycle as `req`.
- Pop latency: 1 cycle; `dout`/`dvalid` are valid after the edge that accepted `pop`.
- Write-to-read: data pushed on edge N can be popped on edge N+1 and appears on `dout` after that edge. There is no same-cycle bypass.
- `pcount`, `empty` and `full` reflect the edge's push/pop outcome immediately after that edge.

## Configuration
- `QCTRL_ERR_EN` defined:
  - `err` is set on the edge after any cycle with `pop & empty`.
  - It stays 1 until reset.
- `QCTRL_ERR_EN` undefined:
  - `err` is tied to 0; no error logic is compiled.
  - All other behaviour is identical.

## Test plan
- **Reset:** drive `rst_n = 0` mid-clock with any state -> immediately `pcount = 0`, `empty = 1`, `full = 0`, `dvalid = 0`, `gnt0 = gnt1 = 0`, `err = 0`.
- **Fill and stall:** req0 only, `din0 = 0x11`..`0x17` on 7 cycles -> `gnt0 = 1` each cycle, `pcount` 1..7, `full = 1`. An 8th req0 gives `gnt0 = 0` and `pcount` stays 7.
- **Round-robin:** both requests held from empty with `din0 = 0xA0`, `din1 = 0xB0`, then pop 4 times -> grants go 0,1,0,1. Popped `dout` is A0, B0, A0, B0, each with `dvalid = 1`.
- **Full with pop and push:** full queue, `pop = 1` and `req1 = 1` with `din1 = 0x5A` in the same cycle -> `gnt1 = 1`, `pcount` stays 7, `dout` = oldest entry. Continue popping 7 times: the last `dout` is `0x5A`, exercising pointer wrap.
- **Underflow:** pop on empty -> `dvalid = 0`, `pcount = 0`. With `QCTRL_ERR_EN`, `err = 1` after the edge and it stays 1. Without the macro, `err` stays 0.
- **Reset mid-stream:** at `pcount = 4`, pulse `rst_n` low -> `pcount = 0`, `empty = 1`. Then push `0x55` and pop -> `dout = 0x55`, `dvalid = 1`.
